// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: RV32I major opcodes
// (also used by the main decoder), loader state encoding, opcode legality.
package imem_loader_pkg;

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        LD_IDLE,
        LD_LEN_LO,
        LD_LEN_HI,
        LD_DATA,
        LD_WRITE,
        LD_DONE,
        LD_ERR
    } ld_state_t;

    function automatic logic opcode_legal(input logic [6:0] op);
        case (op)
            OP_OP, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_SYSTEM: return 1'b1;
            default:                                      return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/imem_loader.sv
// Boot loader: receives a 16-bit little-endian word count then N little-endian
// 32-bit words from a byte stream and writes them to instruction memory.
// Ports: clk, rst_n (async low); start pulse; rx_valid/rx_data/rx_ready byte
// input; imem_we/imem_addr/imem_wdata write port; cpu_rst_n core reset;
// busy/done/err_len status; illegal_cnt saturating unsupported-opcode count.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic              done,
    output logic              err_len,
    output logic [7:0]        illegal_cnt
);

    localparam logic [31:0] CAP = 32'd1 << ADDR_W;

    ld_state_t         state;
    logic [15:0]       len;
    logic [1:0]        byte_cnt;
    logic [31:0]       word;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        ill;

    logic        xfer;
    logic [15:0] len_next;
    logic        too_big;
    logic        last_word;

    assign xfer     = rx_valid & rx_ready;
    assign len_next = {rx_data, len[7:0]};
    assign too_big  = {16'd0, len_next} > CAP;
    // Compare in 32 bits so N = 2^ADDR_W ends after address 2^ADDR_W-1
    // even though the address register itself wraps to 0.
    assign last_word = ({{(32-ADDR_W){1'b0}}, addr} + 32'd1)
                       == {16'd0, len};

    always_comb begin
        rx_ready = 1'b0;
        case (state)
            LD_LEN_LO, LD_LEN_HI, LD_DATA: rx_ready = 1'b1;
            default:                       rx_ready = 1'b0;
        endcase
    end

    assign imem_we     = (state == LD_WRITE);
    assign imem_addr   = addr;
    assign imem_wdata  = word;
    assign busy        = rx_ready | imem_we;
    assign done        = (state == LD_DONE);
    assign err_len     = (state == LD_ERR);
    assign cpu_rst_n   = (state == LD_DONE);
    assign illegal_cnt = ill;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= LD_IDLE;
            len      <= '0;
            byte_cnt <= '0;
            word     <= '0;
            addr     <= '0;
            ill      <= '0;
        end else begin
            case (state)
                LD_IDLE, LD_DONE, LD_ERR: begin
                    if (start) begin
                        state    <= LD_LEN_LO;
                        addr     <= '0;
                        ill      <= '0;
                        byte_cnt <= '0;
                    end
                end
                LD_LEN_LO: begin
                    if (xfer) begin
                        len[7:0] <= rx_data;
                        state    <= LD_LEN_HI;
                    end
                end
                LD_LEN_HI: begin
                    if (xfer) begin
                        len[15:8] <= rx_data;
                        byte_cnt  <= '0;
                        if (len_next == 16'd0)
                            state <= LD_DONE;
                        else if (too_big)
                            state <= LD_ERR;
                        else
                            state <= LD_DATA;
                    end
                end
                LD_DATA: begin
                    if (xfer) begin
                        word[{byte_cnt, 3'b000} +: 8] <= rx_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3)
                            state <= LD_WRITE;
                    end
                end
                LD_WRITE: begin
                    addr <= addr + 1'b1;
                    if (!opcode_legal(word[6:0]) && ill != 8'hFF)
                        ill <= ill + 8'd1;
                    state <= last_word ? LD_DONE : LD_DATA;
                end
                default: state <= LD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomised scoreboard bench for imem_loader: expected writes are queued
// from a word-level model and popped by a monitor on every imem_we.
module tb_imem_loader;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_rst_n;
    logic          busy;
    logic          done;
    logic          err_len;
    logic [7:0]    illegal_cnt;

    imem_loader #(.ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done),
        .err_len(err_len), .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  tests = 0;
    int  fails = 0;

    logic [6:0] legal_ops [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
                                   7'h6F, 7'h67, 7'h37, 7'h17, 7'h73};

    function automatic bit model_legal(input logic [31:0] w);
        foreach (legal_ops[i])
            if (w[6:0] == legal_ops[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the head of the queue.
    always @(negedge clk) begin
        if (imem_we !== 1'b0) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: addr %h data %h",
                         imem_addr, imem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 32'(imem_addr), e.addr);
                chk("wr_data", imem_wdata, e.data);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rx_ready"}, 32'(rx_ready), 0);
        chk({tag, "_imem_we"}, 32'(imem_we), 0);
        chk({tag, "_imem_addr"}, 32'(imem_addr), 0);
        chk({tag, "_imem_wdata"}, imem_wdata, 0);
        chk({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_err_len"}, 32'(err_len), 0);
        chk({tag, "_illegal_cnt"}, 32'(illegal_cnt), 0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 1);
        chk("core_held_after_start", 32'(cpu_rst_n), 0);
    endtask

    // Called at #1 after a rising edge; returns at #1 after the edge on
    // which the byte was accepted.
    task automatic send_byte(input logic [7:0] b, input bit gaps,
                             input bit glitch);
        int k;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        rx_valid = 1'b1;
        rx_data  = b;
        start    = glitch;
        k = 0;
        forever begin
            @(negedge clk);
            if (rx_ready === 1'b1) break;
            k++;
            if (k > 50) begin
                tests++;
                fails++;
                $display("FAIL rx_ready_timeout: byte %h never accepted", b);
                rx_valid = 1'b0;
                start = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic run_load(input string tag, input int n,
                            input logic [31:0] words[$],
                            input bit gaps, input bit glitch);
        int  exp_ill;
        bit  ok;
        int  k;
        logic [15:0] nh;
        nh = 16'(n);
        ok = (n != 0) && (n <= (1 << AW));
        exp_ill = 0;
        if (ok) begin
            for (int i = 0; i < n; i++) begin
                wr_t e;
                e.addr = i;
                e.data = words[i];
                exp_q.push_back(e);
                if (!model_legal(words[i]) && exp_ill < 255) exp_ill++;
            end
        end
        pulse_start();
        send_byte(nh[7:0], gaps, 1'b0);
        send_byte(nh[15:8], gaps, 1'b0);
        if (ok) begin
            for (int i = 0; i < n; i++) begin
                for (int j = 0; j < 4; j++) begin
                    logic [31:0] w;
                    w = words[i];
                    send_byte(w[8*j +: 8], gaps,
                              glitch && (i == 0) && (j == 2));
                end
            end
        end
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (busy === 1'b1 && k < 20);
        chk({tag, "_busy_end"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), (n <= (1 << AW)) ? 1 : 0);
        chk({tag, "_err_len"}, 32'(err_len), (n > (1 << AW)) ? 1 : 0);
        chk({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), (n <= (1 << AW)) ? 1 : 0);
        chk({tag, "_rx_ready"}, 32'(rx_ready), 0);
        chk({tag, "_illegal_cnt"}, 32'(illegal_cnt), exp_ill);
        chk({tag, "_pending_writes"}, exp_q.size(), 0);
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom();
        if ($urandom_range(0, 3) != 0)
            w[6:0] = legal_ops[$urandom_range(0, 9)];
        return w;
    endfunction

    initial begin
        logic [31:0] wq[$];
        int n;

        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        wq = '{32'h00100093, 32'h00208133};
        run_load("basic", 2, wq, 1'b0, 1'b0);

        wq.delete();
        run_load("len_zero", 0, wq, 1'b0, 1'b0);

        run_load("len_over", 1025, wq, 1'b0, 1'b0);
        wq = '{rand_word(), rand_word(), rand_word()};
        run_load("after_err", 3, wq, 1'b0, 1'b0);

        wq = '{32'hFFFFFFFF};
        run_load("one_illegal", 1, wq, 1'b0, 1'b0);

        wq.delete();
        for (int i = 0; i < 300; i++) wq.push_back(32'hFFFFFFFF);
        run_load("sat_illegal", 300, wq, 1'b0, 1'b0);

        for (int t = 0; t < 6; t++) begin
            wq.delete();
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) wq.push_back(rand_word());
            run_load("random", n, wq, 1'b1, 1'b1);
        end

        // Reset in the middle of a word: load abandoned, no writes follow.
        pulse_start();
        send_byte(8'h02, 1'b0, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'h93, 1'b0, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midload");
        rx_valid = 1'b1;
        rx_data  = 8'h10;
        repeat (3) @(posedge clk);
        #1;
        rx_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check_reset_outputs("after_reset");

        wq.delete();
        for (int i = 0; i < (1 << AW); i++) wq.push_back(rand_word());
        run_load("full", 1 << AW, wq, 1'b0, 1'b0);
        chk("full_addr_wrapped", 32'(imem_addr), 0);
        repeat (4) @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDR_W, default 10, width of the instruction-memory word address (capacity 2^ADDR_W words).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  single-cycle pulse that begins a load.
REQ-005 rx_valid  input  1  byte-source valid.
REQ-006 rx_data  input  8  byte from the byte source (UART receiver).
REQ-007 rx_ready  output  1  loader can accept a byte this cycle.
REQ-008 imem_we  output  1  instruction-memory write strobe.
REQ-009 imem_addr  output  ADDR_W  word address of the write.
REQ-010 imem_wdata  output  32  instruction word written.
REQ-011 cpu_rst_n  output  1  holds the core in reset while low.
REQ-012 busy  output  1  a load is in progress.
REQ-013 done  output  1  the last load completed successfully.
REQ-014 err_len  output  1  the last load aborted because its length exceeded capacity.
REQ-015 illegal_cnt  output  8  count of written words with an unsupported opcode.

Function
REQ-016 A byte SHALL transfer only on a cycle with rx_valid=1 and rx_ready=1; rx_ready SHALL NOT depend combinationally on rx_valid.
REQ-017 States SHALL be IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERR; rx_ready=1 only in LEN_LO, LEN_HI and DATA.
REQ-018 IDLE, DONE or ERR with start=1 -> LEN_LO; clear done, err_len, illegal_cnt and the word address; drive cpu_rst_n=0.
REQ-019 start SHALL be ignored in LEN_LO, LEN_HI, DATA and WRITE.
REQ-020 LEN_LO SHALL capture the transferred byte as N[7:0]; LEN_HI SHALL capture it as N[15:8].
REQ-021 On the LEN_HI transfer: N=0 -> DONE; N>2^ADDR_W -> ERR; otherwise -> DATA.
REQ-022 DATA SHALL assemble 4 transferred bytes little-endian (first byte = bits 7:0) and enter WRITE on the 4th transfer.
REQ-023 WRITE SHALL last exactly one cycle with imem_we=1; imem_addr and imem_wdata SHALL hold the current address and assembled word.
REQ-024 After WRITE, the address SHALL increment; the loader SHALL enter DONE after the Nth word and return to DATA otherwise.
REQ-025 imem_we SHALL be 0 in every state except WRITE.
REQ-026 In WRITE, a word whose bits 6:0 are not one of 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111 or 1110011 SHALL increment illegal_cnt.
REQ-027 illegal_cnt SHALL saturate at 255; the word SHALL be written regardless.
REQ-028 busy SHALL be 1 exactly in LEN_LO, LEN_HI, DATA and WRITE.
REQ-029 done=1 and cpu_rst_n=1 only in DONE.
REQ-030 err_len=1 and cpu_rst_n=0 in ERR.
REQ-031 With N=2^ADDR_W, the final write SHALL be to address 2^ADDR_W-1; the address wrap to 0 after it SHALL NOT be written.
REQ-032 Throughput SHALL be one byte per cycle in DATA, plus one WRITE cycle per word.

Reset
REQ-033 On rst_n=0 the block SHALL asynchronously enter IDLE with rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_rst_n=0, busy=0, done=0, err_len=0, illegal_cnt=0.
REQ-034 Reset asserted mid-load SHALL abandon the load; no further imem write SHALL occur.

Structure
REQ-035 The shared riscv package SHALL hold the opcode constants (shared with the main decoder), the loader state enum and a pure function returning opcode legality.
REQ-036 imem_loader SHALL be a single module with no sub-module; the byte assembler and counters SHALL be inline.

Verification
REQ-037 Reset, then start with bytes 02 00 | 93 00 10 00 | 33 81 20 00 at one byte per cycle -> writes 0x00100093@0 and 0x00208133@1, done=1, cpu_rst_n=1, illegal_cnt=0.
REQ-038 Header 00 00 -> DONE with no imem_we pulse.
REQ-039 Header 01 04 with ADDR_W=10 (N=1025) -> ERR, err_len=1, cpu_rst_n=0, rx_ready=0; a following start then restarts cleanly.
REQ-040 One word FF FF FF FF -> written at address 0, illegal_cnt=1; 300 such words -> illegal_cnt=255.
REQ-041 Random rx_valid gaps plus a start pulse during DATA -> identical memory image, start ignored.
REQ-042 rst_n pulsed low after the 2nd data byte -> immediate IDLE, imem_we stays 0, all outputs at reset values.
